ips_sensor_filter: RTL and testbench
====================================

// Module: ips_sensor_filter
// PURPOSE
//  Conditions raw inductive-proximity-sensor (IPS) inputs before the line-follow/align controller.
//  - Per-channel: 2-FF synchroniser, then counter-based debounce; emits clean L/M/R levels.
//  - Intersection detector FSM: one-cycle cross_pulse per physical crossing, with cooldown
//    so sensor bounce at the crossing edge does not double-count.
//  Output L/M/R drive the align controller's L/M/R inputs directly.
// PARAMETERS
//  DEBOUNCE_CYCLES  50000  consecutive cycles a synced input must differ before filtered level flips (>=1)
//  COOLDOWN_CYCLES  250000 cycles after leaving all-on (3'b111) during which re-entry is not a new crossing (>=1)
//  CNT_W            18     width of debounce/cooldown counters; must hold max(DEBOUNCE,COOLDOWN)-1
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  asynchronous active-low reset
//  ips_raw      in   3  raw sensor pins {L,M,R}, asynchronous to clk, 1 = line detected
//  L            out  1  filtered left sensor
//  M            out  1  filtered middle sensor
//  R            out  1  filtered right sensor
//  pattern_chg  out  1  1-cycle pulse when any of L/M/R changes
//  cross_pulse  out  1  1-cycle pulse on each new intersection (L&M&R)
//  glitch_cnt   out  8  (only with IPS_GLITCH_CNT_EN) saturating count of rejected glitches
// BEHAVIOUR
//  Reset: all sync flops, L/M/R, pattern_chg, cross_pulse, counters = 0; FSM = IDLE. Reset
//   asserted mid-debounce or mid-cooldown discards progress; no pulse emitted on release.
//  Sync: s1 <= ips_raw; s2 <= s1 (per bit). Only s2 is used downstream.
//  Debounce (per channel, counter dc, filtered f):
//   - s2 == f: dc <= 0.
//   - s2 != f and dc <  DEBOUNCE_CYCLES-1: dc <= dc+1.
//   - s2 != f and dc == DEBOUNCE_CYCLES-1: f <= s2, dc <= 0.
//   - DEBOUNCE_CYCLES=1: f follows s2 with one extra cycle.
//   Latency raw edge -> f edge = 2 + DEBOUNCE_CYCLES clocks (stable input).
//   Glitch = cycle where s2 == f while dc != 0.
//  pattern_chg: registered; high the cycle after {L,M,R} differs from its previous value.
//  Intersection FSM (input allon = L&M&R, registered outputs):
//   IDLE : allon -> cross_pulse=1 for one cycle, go ON.
//   ON   : stay while allon; !allon -> COOL, cool timer <= 0.
//   COOL : allon -> ON with NO pulse (bounce); timer == COOLDOWN_CYCLES-1 -> IDLE; else timer+1.
//   Undefined encodings -> IDLE. cross_pulse never high two consecutive cycles.
//  Simultaneous: channels flipping in the same cycle produce a single pattern_chg pulse;
//   if that flip makes allon true in IDLE, cross_pulse asserts the cycle after L/M/R update.
// CONFIGURATION
//  IPS_GLITCH_CNT_EN defined: glitch_cnt port present; increments by 1 per cycle in which
//   >=1 channel records a glitch (multiple channels same cycle = +1); saturates at 8'hFF;
//   reset to 0. Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  ips_pkg: FSM state enum (IDLE/ON/COOL, 2 bits), channel index constants CH_L=2, CH_M=1, CH_R=0.
//  Sub-module ips_debounce_ch: sync + debounce for one bit (ports clk, rst_n, raw, level, glitch);
//   instantiated 3x. Intersection FSM, pattern_chg and glitch counter live in the top.
// TESTING (sim params DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=8)
//  1. Reset: rst_n=0 with ips_raw=3'b111 -> L/M/R=0, no pulses; release -> L/M/R=1 at 6 clocks, one cross_pulse next cycle.
//  2. Glitch: M raw high 3 clocks then low -> M stays 0, no pattern_chg; glitch_cnt=1 with macro.
//  3. Step: R raw 0->1 held -> R rises exactly 6 clocks after edge; pattern_chg pulses 1 cycle.
//  4. Bounce: 111 held, drop to 101 for 5 clocks, back to 111 -> exactly one cross_pulse total.
//  5. Two crossings: 111, then 010 for 20 clocks, then 111 -> two cross_pulses.
//  6. Async reset mid-COOL (timer=5) -> FSM IDLE, outputs 0; re-applied 111 gives pulse after 6+1 clocks.

Source files
------------

// File: rtl/ips_pkg.sv
// Shared types for the IPS sensor filter: intersection FSM state encoding and channel indices.
// Optional glitch counter in the top is enabled with IPS_GLITCH_CNT_EN.
package ips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    COOL = 2'd2
  } ips_state_e;

  localparam int CH_L = 2;
  localparam int CH_M = 1;
  localparam int CH_R = 0;
  localparam int N_CH = 3;

endpackage

// File: rtl/ips_debounce_ch.sv
// One IPS channel: 2-FF synchroniser followed by a counter debounce.
// glitch flags a cycle where the input returned to the filtered level before the count completed.
module ips_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 18
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic glitch
);

  localparam logic [CNT_W-1:0] DC_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] dc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      dc    <= '0;
      level <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == level) begin
        dc <= '0;
      end else if (dc == DC_LAST) begin
        level <= s2;
        dc    <= '0;
      end else begin
        dc <= dc + 1'b1;
      end
    end
  end

  assign glitch = (s2 == level) && (dc != '0);

endmodule

// File: rtl/ips_sensor_filter.sv
// IPS conditioning top: three debounced channels, pattern-change pulse and intersection detector.
// Define IPS_GLITCH_CNT_EN to add the saturating glitch_cnt output.
module ips_sensor_filter
  import ips_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int COOLDOWN_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] ips_raw,
  output logic       L,
  output logic       M,
  output logic       R,
  output logic       pattern_chg,
  output logic       cross_pulse
`ifdef IPS_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_CYCLES - 1);

  logic [N_CH-1:0] lvl;
  logic [N_CH-1:0] glitch;
  logic [N_CH-1:0] lvl_prev;
  logic            allon;
  ips_state_e      state;
  logic [CNT_W-1:0] timer;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    ips_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (ips_raw[gi]),
      .level (lvl[gi]),
      .glitch(glitch[gi])
    );
  end

  assign L     = lvl[CH_L];
  assign M     = lvl[CH_M];
  assign R     = lvl[CH_R];
  assign allon = &lvl;

  // All channels compare as one vector, so simultaneous flips give a single pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_prev    <= '0;
      pattern_chg <= 1'b0;
    end else begin
      lvl_prev    <= lvl;
      pattern_chg <= (lvl != lvl_prev);
    end
  end

  // Re-entering all-on during COOL is treated as edge bounce, not a new crossing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      cross_pulse <= 1'b0;
    end else begin
      cross_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (allon) begin
            cross_pulse <= 1'b1;
            state       <= ON;
          end
        end
        ON: begin
          if (!allon) begin
            state <= COOL;
            timer <= '0;
          end
        end
        COOL: begin
          if (allon) begin
            state <= ON;
          end else if (timer == COOL_LAST) begin
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IPS_GLITCH_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_cnt <= 8'h00;
    end else if ((|glitch) && (glitch_cnt != 8'hFF)) begin
      glitch_cnt <= glitch_cnt + 8'h01;
    end
  end
`else
  logic glitch_unused;
  assign glitch_unused = |glitch;
`endif

endmodule

// File: tb/tb_ips_sensor_filter.sv
// Directed self-checking bench for ips_sensor_filter with DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=8.
// Covers reset, glitch rejection, step latency, crossing bounce, two crossings and reset mid-cooldown.
module tb_ips_sensor_filter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] ips_raw = 3'b111;
  logic       L, M, R, pattern_chg, cross_pulse;
`ifdef IPS_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  int   checks = 0;
  int   passed = 0;
  int   cross_seen = 0;
  int   chg_seen = 0;
  logic prev_cross = 1'b0;

  always #5 clk = ~clk;

  ips_sensor_filter #(
    .DEBOUNCE_CYCLES(4),
    .COOLDOWN_CYCLES(8),
    .CNT_W          (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ips_raw    (ips_raw),
    .L          (L),
    .M          (M),
    .R          (R),
    .pattern_chg(pattern_chg),
    .cross_pulse(cross_pulse)
`ifdef IPS_GLITCH_CNT_EN
    ,
    .glitch_cnt (glitch_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] lmr();
    return 8'({L, M, R});
  endfunction

  // Advance n clocks, sampling 1 time unit after each rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (cross_pulse) cross_seen++;
      if (pattern_chg) chg_seen++;
      chk("cross_back_to_back", 8'(cross_pulse & prev_cross), 8'd0);
      prev_cross = cross_pulse;
    end
  endtask

  initial begin
    // 1. Reset held with all sensors on, then release
    rst_n   = 1'b0;
    ips_raw = 3'b111;
    tick(3);
    chk("rst_lmr", lmr(), 8'h0);
    chk("rst_pattern_chg", 8'(pattern_chg), 8'h0);
    chk("rst_cross_pulse", 8'(cross_pulse), 8'h0);
`ifdef IPS_GLITCH_CNT_EN
    chk("rst_glitch_cnt", glitch_cnt, 8'h00);
`endif
    rst_n      = 1'b1;
    cross_seen = 0;
    chg_seen   = 0;
    tick(5);
    chk("rel_lmr_clk5", lmr(), 8'h0);
    tick(1);
    chk("rel_lmr_clk6", lmr(), 8'h7);
    chk("rel_cross_clk6", 8'(cross_pulse), 8'h0);
    tick(1);
    chk("rel_cross_clk7", 8'(cross_pulse), 8'h1);
    chk("rel_chg_clk7", 8'(pattern_chg), 8'h1);
    tick(1);
    chk("rel_cross_clk8", 8'(cross_pulse), 8'h0);
    chk("rel_chg_clk8", 8'(pattern_chg), 8'h0);
    chk("rel_cross_count", 8'(cross_seen), 8'd1);

    ips_raw = 3'b000;
    tick(30);
    chk("settle0_lmr", lmr(), 8'h0);

    // 2. Middle high for 3 clocks only: rejected as a glitch
    chg_seen = 0;
    ips_raw  = 3'b010;
    tick(3);
    ips_raw = 3'b000;
    tick(10);
    chk("glitch_lmr", lmr(), 8'h0);
    chk("glitch_chg_count", 8'(chg_seen), 8'd0);
`ifdef IPS_GLITCH_CNT_EN
    chk("glitch_cnt_1", glitch_cnt, 8'h01);
`endif

    // 3. Right sensor step: exactly 6 clocks latency
    chg_seen = 0;
    ips_raw  = 3'b001;
    tick(5);
    chk("step_lmr_clk5", lmr(), 8'h0);
    tick(1);
    chk("step_lmr_clk6", lmr(), 8'h1);
    chk("step_chg_clk6", 8'(pattern_chg), 8'h0);
    tick(1);
    chk("step_chg_clk7", 8'(pattern_chg), 8'h1);
    tick(1);
    chk("step_chg_clk8", 8'(pattern_chg), 8'h0);
    chk("step_chg_count", 8'(chg_seen), 8'd1);
`ifdef IPS_GLITCH_CNT_EN
    chk("step_glitch_cnt", glitch_cnt, 8'h01);
`endif
    ips_raw = 3'b000;
    tick(12);
    chk("settle1_lmr", lmr(), 8'h0);

    // 4. Crossing with middle bounce inside cooldown: one pulse only
    cross_seen = 0;
    chg_seen   = 0;
    ips_raw    = 3'b111;
    tick(10);
    chk("bounce_first_pulse", 8'(cross_seen), 8'd1);
    ips_raw = 3'b101;
    tick(5);
    ips_raw = 3'b111;
    tick(20);
    chk("bounce_lmr", lmr(), 8'h7);
    chk("bounce_cross_count", 8'(cross_seen), 8'd1);
    chk("bounce_chg_count", 8'(chg_seen), 8'd3);

    // 5. Leave long enough for cooldown to expire, then a second crossing
    cross_seen = 0;
    ips_raw    = 3'b010;
    tick(20);
    chk("two_mid_lmr", lmr(), 8'h2);
    chk("two_mid_cross_count", 8'(cross_seen), 8'd0);
    ips_raw = 3'b111;
    tick(6);
    chk("two_lmr_clk6", lmr(), 8'h7);
    chk("two_cross_clk6", 8'(cross_pulse), 8'h0);
    tick(1);
    chk("two_cross_clk7", 8'(cross_pulse), 8'h1);
    tick(3);
    chk("two_cross_count", 8'(cross_seen), 8'd1);

    // 6. Asynchronous reset while cooling down (timer at 5)
    ips_raw = 3'b000;
    tick(12);
    #2 rst_n = 1'b0;
    #1;
    chk("cool_rst_lmr", lmr(), 8'h0);
    chk("cool_rst_cross", 8'(cross_pulse), 8'h0);
    chk("cool_rst_chg", 8'(pattern_chg), 8'h0);
`ifdef IPS_GLITCH_CNT_EN
    chk("cool_rst_glitch_cnt", glitch_cnt, 8'h00);
`endif
    ips_raw = 3'b111;
    tick(2);
    rst_n      = 1'b1;
    cross_seen = 0;
    tick(6);
    chk("cool_rel_lmr_clk6", lmr(), 8'h7);
    chk("cool_rel_cross_clk6", 8'(cross_pulse), 8'h0);
    tick(1);
    chk("cool_rel_cross_clk7", 8'(cross_pulse), 8'h1);
    tick(2);
    chk("cool_rel_cross_count", 8'(cross_seen), 8'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
